imm_gen_pipe: RTL and testbench

//  Pipelined, parametrised immediate generator for the decode stage.
//  - Extracts I/S/B/U/J immediates (optionally CSR zimm) from a full instruction word and sign-extends them to XLEN.
//  - Result is registered into a 2-entry output FIFO with valid/ready handshakes.
//  - Carries a sideband tag (PC/rd/etc.) alongside each result.
//  - Flags unsupported immediate types and counts them.

---
 rtl/imm_gen_pipe_if.sv | 33 +++
 rtl/imm_gen_pipe.sv | 137 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
//==============================================================================
// Module : imm_gen_pipe_if
// Brief  : Upstream/downstream handshake bundle for the immediate generator.
// Rev    : 1.0  initial release
//==============================================================================
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [2:0]        in_imm_type;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_imm;
    logic              out_illegal;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_instr, in_imm_type, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_imm_type, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_illegal, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
//==============================================================================
// Module : imm_gen_pipe
// Brief  : Decode-stage immediate generator with a 2-entry output FIFO.
// Config : IMM_GEN_CSR_ZIMM_EN makes type 5 a zero-extended CSR zimm.
// Rev    : 1.0  initial release
//==============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    imm_gen_pipe_if.slave     bus,
    output logic [CNT_W-1:0]  illegal_cnt
);

    localparam logic [2:0] c_type_i = 3'd0;
    localparam logic [2:0] c_type_s = 3'd1;
    localparam logic [2:0] c_type_b = 3'd2;
    localparam logic [2:0] c_type_u = 3'd3;
    localparam logic [2:0] c_type_j = 3'd4;
    localparam logic [2:0] c_type_z = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [31:0]      w_i;
    logic [63:0]      w_imm64;
    logic             w_illegal;
    entry_t           w_new;
    logic             w_push;
    logic             w_pop;
    logic             w_cnt_max;
    logic             w_unused;

    logic [1:0]       r_count;
    entry_t           r_slot0;
    entry_t           r_slot1;
    logic [CNT_W-1:0] r_illegal_cnt;

    assign w_i = bus.in_instr;

    // Decode at full 64-bit width; the XLEN slice below keeps the sign
    // extension correct for both legal widths without zero-width replicates.
    always_comb begin
        w_imm64   = '0;
        w_illegal = 1'b0;
        case (bus.in_imm_type)
            c_type_i: w_imm64 = {{52{w_i[31]}}, w_i[31:20]};
            c_type_s: w_imm64 = {{52{w_i[31]}}, w_i[31:25], w_i[11:7]};
            c_type_b: w_imm64 = {{51{w_i[31]}}, w_i[31], w_i[7], w_i[30:25],
                                 w_i[11:8], 1'b0};
            c_type_u: w_imm64 = {{32{w_i[31]}}, w_i[31:12], 12'b0};
            c_type_j: w_imm64 = {{43{w_i[31]}}, w_i[31], w_i[19:12], w_i[20],
                                 w_i[30:21], 1'b0};
`ifdef IMM_GEN_CSR_ZIMM_EN
            c_type_z: w_imm64 = {59'b0, w_i[19:15]};
`else
            c_type_z: w_illegal = 1'b1;
`endif
            default:  w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_new         = '0;
        w_new.imm     = w_illegal ? '0 : w_imm64[XLEN-1:0];
        w_new.illegal = w_illegal;
        w_new.tag     = bus.in_tag;
    end

    // Opcode bits and the upper decode bits (XLEN=32) are intentionally unused.
    assign w_unused = ^{w_i[6:0], w_imm64};

    assign bus.in_ready  = (r_count != 2'd2);
    assign bus.out_valid = (r_count != 2'd0);
    assign w_push        = bus.in_valid && bus.in_ready;
    assign w_pop         = bus.out_valid && bus.out_ready;

    assign bus.out_imm     = r_slot0.imm;
    assign bus.out_illegal = r_slot0.illegal;
    assign bus.out_tag     = r_slot0.tag;

    // slot0 is always the head; slot1 holds the second entry when count is 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_slot0 <= w_new;
                    end else begin
                        r_slot1 <= w_new;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_slot0 <= r_slot1;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Only reachable with count 1: the new entry replaces the head.
                    r_slot0 <= w_new;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_cnt_max = &r_illegal_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= '0;
        end else if (w_push && !flush && w_new.illegal && !w_cnt_max) begin
            r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
        end
    end

    assign illegal_cnt = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
//==============================================================================
// Module : tb_imm_gen_pipe
// Brief  : Two DUTs (XLEN=32/CNT_W=16 and XLEN=64/CNT_W=2) driven in lockstep.
// Rev    : 1.0  initial release
//==============================================================================
module tb_imm_gen_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) if_a ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) if_b ();
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if_a), .illegal_cnt(cnt_a)
    );
    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if_b), .illegal_cnt(cnt_b)
    );

    typedef struct {
        logic [63:0] imm;
        logic        ill;
        logic [7:0]  tag;
    } exp_t;

    exp_t q[$];
    int   exp_cnt_a = 0;
    int   exp_cnt_b = 0;
    int   checks    = 0;
    int   errors    = 0;
    bit   last_push = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference immediate from the format table, using signed arithmetic.
    function automatic exp_t ref_entry(logic [31:0] i, logic [2:0] t, logic [7:0] tag);
        exp_t   e;
        longint v;
        logic   ill;
        v   = 0;
        ill = 1'b0;
        case (t)
            3'd0: v = longint'($signed(i[31:20]));
            3'd1: v = longint'($signed({i[31:25], i[11:7]}));
            3'd2: v = longint'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2;
            3'd3: v = longint'($signed(i[31:12])) * 4096;
            3'd4: v = longint'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
            3'd5: begin
`ifdef IMM_GEN_CSR_ZIMM_EN
                v = longint'(i[19:15]);
`else
                ill = 1'b1;
`endif
            end
            default: ill = 1'b1;
        endcase
        e.imm = ill ? 64'd0 : 64'(v);
        e.ill = ill;
        e.tag = tag;
        return e;
    endfunction

    task automatic drive(bit v, logic [31:0] i, logic [2:0] t, logic [7:0] tag, bit ordy, bit fl);
        if_a.in_valid = v;   if_b.in_valid = v;
        if_a.in_instr = i;   if_b.in_instr = i;
        if_a.in_imm_type = t; if_b.in_imm_type = t;
        if_a.in_tag = tag;   if_b.in_tag = tag;
        if_a.out_ready = ordy; if_b.out_ready = ordy;
        flush = fl;
    endtask

    task automatic check_zero(string nm);
        chk({nm, "_valid_a"}, 64'(if_a.out_valid), 64'd0);
        chk({nm, "_valid_b"}, 64'(if_b.out_valid), 64'd0);
        chk({nm, "_imm_a"},   64'(if_a.out_imm), 64'd0);
        chk({nm, "_imm_b"},   if_b.out_imm, 64'd0);
        chk({nm, "_ill_a"},   64'(if_a.out_illegal), 64'd0);
        chk({nm, "_ill_b"},   64'(if_b.out_illegal), 64'd0);
        chk({nm, "_tag_a"},   64'(if_a.out_tag), 64'd0);
        chk({nm, "_tag_b"},   64'(if_b.out_tag), 64'd0);
        chk({nm, "_rdy_a"},   64'(if_a.in_ready), 64'd1);
        chk({nm, "_rdy_b"},   64'(if_b.in_ready), 64'd1);
        chk({nm, "_cnt_a"},   64'(cnt_a), 64'd0);
        chk({nm, "_cnt_b"},   64'(cnt_b), 64'd0);
    endtask

    // One clock with the currently driven inputs; model advanced then compared.
    task automatic cycle();
        exp_t e;
        exp_t d;
        bit   push;
        bit   pop;
        chk("in_ready_a", 64'(if_a.in_ready), 64'(q.size() < 2));
        chk("in_ready_b", 64'(if_b.in_ready), 64'(q.size() < 2));
        push = if_a.in_valid && (q.size() < 2);
        pop  = (q.size() > 0) && if_a.out_ready;
        e    = ref_entry(if_a.in_instr, if_a.in_imm_type, if_a.in_tag);
        @(posedge clk);
        #1;
        last_push = push;
        if (flush) begin
            q.delete();
        end else begin
            if (pop) d = q.pop_front();
            if (push) begin
                q.push_back(e);
                if (e.ill) begin
                    if (exp_cnt_a < 65535) exp_cnt_a++;
                    if (exp_cnt_b < 3)     exp_cnt_b++;
                end
            end
        end
        chk("out_valid_a", 64'(if_a.out_valid), 64'(q.size() > 0));
        chk("out_valid_b", 64'(if_b.out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("imm_a", 64'(if_a.out_imm), {32'd0, q[0].imm[31:0]});
            chk("imm_b", if_b.out_imm, q[0].imm);
            chk("ill_a", 64'(if_a.out_illegal), 64'(q[0].ill));
            chk("ill_b", 64'(if_b.out_illegal), 64'(q[0].ill));
            chk("tag_a", 64'(if_a.out_tag), 64'(q[0].tag));
            chk("tag_b", 64'(if_b.out_tag), 64'(q[0].tag));
        end
        chk("cnt_a", 64'(cnt_a), 64'(exp_cnt_a));
        chk("cnt_b", 64'(cnt_b), 64'(exp_cnt_b));
    endtask

    task automatic directed(string nm, logic [31:0] i, logic [2:0] t, logic [7:0] tag,
                            logic [31:0] x32, logic [63:0] x64, bit xill);
        drive(1, i, t, tag, 1, 0);
        cycle();
        chk({nm, "_const_a"}, 64'(if_a.out_imm), {32'd0, x32});
        chk({nm, "_const_b"}, if_b.out_imm, x64);
        chk({nm, "_const_ill"}, 64'(if_a.out_illegal), 64'(xill));
        drive(0, 32'd0, 3'd0, 8'd0, 1, 0);
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          cur_v;
        logic [31:0] cur_i;
        logic [2:0]  cur_t;
        logic [7:0]  cur_tag;
        int          cnt_before;

        drive(0, 32'd0, 3'd0, 8'd0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        cycle();

        // Reference vectors, one transaction at a time.
        directed("imm_i", 32'hFFF00093, 3'd0, 8'h11, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 0);
        directed("imm_s", 32'h0020A423, 3'd1, 8'h22, 32'h00000008, 64'h00000000_00000008, 0);
        directed("imm_b", 32'hFE000EE3, 3'd2, 8'h33, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 0);
        directed("imm_u", 32'h123450B7, 3'd3, 8'h44, 32'h12345000, 64'h00000000_12345000, 0);
`ifdef IMM_GEN_CSR_ZIMM_EN
        directed("zimm", 32'h3401D073, 3'd5, 8'h55, 32'h00000003, 64'd3, 0);
`else
        directed("zimm", 32'h3401D073, 3'd5, 8'h55, 32'h00000000, 64'd0, 1);
`endif

        // Backpressure: third push must stall until a slot frees.
        drive(1, 32'hABCDE0B7, 3'd3, 8'hA1, 0, 0); cycle();
        drive(1, 32'h80000EE3, 3'd2, 8'hA2, 0, 0); cycle();
        drive(1, 32'h7FF00093, 3'd4, 8'hA3, 0, 0);
        chk("bp_full_rdy", 64'(if_a.in_ready), 64'd0);
        cycle();
        cycle();
        drive(1, 32'h7FF00093, 3'd4, 8'hA3, 1, 0); cycle();
        cycle();
        drive(0, 32'd0, 3'd0, 8'd0, 1, 0);
        repeat (3) cycle();

        // Flush with FIFO full and an illegal push pending.
        drive(1, 32'h00100093, 3'd0, 8'hB1, 0, 0); cycle();
        drive(1, 32'h00200093, 3'd0, 8'hB2, 0, 0); cycle();
        cnt_before = exp_cnt_a;
        drive(1, 32'h00300093, 3'd6, 8'hB3, 0, 1); cycle();
        chk("flush_valid", 64'(if_a.out_valid), 64'd0);
        chk("flush_rdy", 64'(if_a.in_ready), 64'd1);
        chk("flush_cnt", 64'(cnt_a), 64'(cnt_before));
        // Flush while an accepted illegal push is presented: it must be dropped.
        drive(1, 32'h00400093, 3'd7, 8'hB4, 0, 1); cycle();
        drive(0, 32'd0, 3'd0, 8'd0, 1, 0); cycle();

        // Saturation: five illegal pushes pin the 2-bit counter at 3.
        for (int k = 0; k < 5; k++) begin
            drive(1, $urandom, 3'd7, 8'(k), 1, 0);
            cycle();
        end
        chk("sat_cnt_b", 64'(cnt_b), 64'd3);
        drive(0, 32'd0, 3'd0, 8'd0, 1, 0); cycle();

        // Randomized traffic; a stalled offer is held stable.
        cur_v = 0; cur_i = 0; cur_t = 0; cur_tag = 0;
        for (int n = 0; n < 400; n++) begin
            if (!(cur_v && !last_push)) begin
                cur_v   = ($urandom_range(0, 3) != 0);
                cur_i   = $urandom;
                cur_t   = 3'($urandom_range(0, 7));
                cur_tag = 8'($urandom);
            end
            drive(cur_v, cur_i, cur_t, cur_tag, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 24) == 0);
            cycle();
        end

        // Asynchronous reset in the middle of a transfer.
        drive(1, 32'hFFF00093, 3'd0, 8'hC1, 0, 0); cycle();
        drive(1, 32'h00000007, 3'd6, 8'hC2, 0, 0); cycle();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        q.delete();
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        check_zero("async_rst");
        drive(0, 32'd0, 3'd0, 8'd0, 1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        directed("post_rst", 32'h123450B7, 3'd3, 8'hD1, 32'h12345000, 64'h00000000_12345000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
